// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding, default
// frame geometry and the 3-sample majority vote used at each bit centre.
package uart_pkg;

   localparam int UART_DATA_WIDTH = 8;
   localparam int UART_OVERSAMPLE = 16;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // Two-out-of-three vote so a single noisy sample cannot flip a bit.
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the asynchronous serial line. Flops reset to 1
// so that leaving reset looks like an idle line rather than a start bit.
module uart_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   // Shift the raw line through the chain; the last stage is the safe copy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (8N1 style framing). Detects the start edge,
// votes three samples around each bit centre, and hands completed words to a
// one-entry valid/ready output buffer with framing-error and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic                  uart_clk,
   input  logic                  rst,
   input  logic                  baud_tick,
   input  logic                  rx_serial,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  rx_active,
   output logic                  frame_error,
   output logic                  overrun
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

   localparam logic [TICK_W-1:0] LAST_TICK   = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] VOTE_A_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] VOTE_B_TICK = TICK_W'(OVERSAMPLE / 2);
   localparam logic [TICK_W-1:0] SAMPLE_TICK = TICK_W'(OVERSAMPLE / 2 + 1);
   localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(DATA_WIDTH - 1);

   rx_state_t               r_state;
   rx_state_t               w_nextState;
   logic [TICK_W-1:0]       r_tickCnt;
   logic [BIT_W-1:0]        r_bitCnt;
   logic [DATA_WIDTH-1:0]   r_shift;
   logic                    r_prevSin;
   logic                    r_voteA;
   logic                    r_voteB;
   logic [DATA_WIDTH-1:0]   r_rxData;
   logic                    r_rxValid;
   logic                    r_frameError;
   logic                    r_overrun;

   logic                    w_sin;
   logic                    w_vote;
   logic                    w_sampleHit;
   logic                    w_boundary;
   logic                    w_fallEdge;
   logic                    w_stopGood;
   logic                    w_stopBad;
   logic                    w_rxActive;

   uart_sync #(
      .STAGES (2)
   ) u_sync (
      .clk (uart_clk),
      .rst (rst),
      .i_d (rx_serial),
      .o_q (w_sin)
   );

   // The third vote sample is the live synchronized value at the sample tick.
   assign w_vote      = majority3(r_voteA, r_voteB, w_sin);
   assign w_sampleHit = baud_tick && (r_tickCnt == SAMPLE_TICK);
   assign w_boundary  = baud_tick && (r_tickCnt == LAST_TICK);
   assign w_fallEdge  = baud_tick && !w_sin && r_prevSin;

   // State register.
   always_ff @(posedge uart_clk) begin
      if (rst) begin
         r_state <= RX_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic; every transition is qualified by a baud tick.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         RX_IDLE: begin
            if (w_fallEdge) w_nextState = RX_START;
         end
         RX_START: begin
            if (w_sampleHit && w_vote) w_nextState = RX_IDLE;
            else if (w_boundary)       w_nextState = RX_DATA;
         end
         RX_DATA: begin
            if (w_boundary && (r_bitCnt == LAST_BIT)) w_nextState = RX_STOP;
         end
         RX_STOP: begin
            if (w_sampleHit) w_nextState = RX_IDLE;
         end
         default: w_nextState = RX_IDLE;
      endcase
   end

   // State-decoded outputs: busy flag and the two stop-bit outcomes.
   always_comb begin
      w_rxActive = (r_state != RX_IDLE);
      w_stopGood = (r_state == RX_STOP) && w_sampleHit && w_vote;
      w_stopBad  = (r_state == RX_STOP) && w_sampleHit && !w_vote;
   end

   // Tick/bit counters, vote samples and the LSB-first shift register.
   always_ff @(posedge uart_clk) begin
      if (rst) begin
         r_tickCnt <= '0;
         r_bitCnt  <= '0;
         r_shift   <= '0;
         r_prevSin <= 1'b1;
         r_voteA   <= 1'b0;
         r_voteB   <= 1'b0;
      end else if (baud_tick) begin
         r_prevSin <= w_sin;
         if ((r_state == RX_IDLE) || (w_nextState == RX_IDLE)) begin
            r_tickCnt <= '0;
         end else if (r_tickCnt == LAST_TICK) begin
            r_tickCnt <= '0;
         end else begin
            r_tickCnt <= r_tickCnt + 1'b1;
         end
         if (r_tickCnt == VOTE_A_TICK) r_voteA <= w_sin;
         if (r_tickCnt == VOTE_B_TICK) r_voteB <= w_sin;
         if ((r_state == RX_START) && w_boundary) r_bitCnt <= '0;
         if (r_state == RX_DATA) begin
            if (w_sampleHit) r_shift  <= {w_vote, r_shift[DATA_WIDTH-1:1]};
            if (w_boundary)  r_bitCnt <= r_bitCnt + 1'b1;
         end
      end
   end

   // One-entry output buffer: load on good stop, drop and flag when still full.
   always_ff @(posedge uart_clk) begin
      if (rst) begin
         r_rxData     <= '0;
         r_rxValid    <= 1'b0;
         r_frameError <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_frameError <= w_stopBad;
         r_overrun    <= 1'b0;
         if (w_stopGood) begin
            if (!r_rxValid || rx_ready) begin
               r_rxData  <= r_shift;
               r_rxValid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_rxValid && rx_ready) begin
            r_rxValid <= 1'b0;
         end
      end
   end

   assign rx_data     = r_rxData;
   assign rx_valid    = r_rxValid;
   assign rx_active   = w_rxActive;
   assign frame_error = r_frameError;
   assign overrun     = r_overrun;

endmodule
